aes_ctrl_regs: RTL and testbench
================================

# aes_ctrl_regs

Avalon-MM register front end and sequencer for the AES decryption core. Software writes the 128-bit key and the 128-bit encrypted message, then sets START. The block holds `aes_start` to the core, captures the decrypted result on `aes_done`, enforces a cycle timeout, and raises a level interrupt. It sits between the Nios II data bus and the AES datapath, and drives a 32-bit export to the hex displays.

## Interface
- `TIMEOUT`, 4095: maximum cycles `aes_start` stays high without `aes_done`; legal range 1..65535.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `avs_address` in 4: word address.
- `avs_chipselect` in 1: slave select.
- `avs_read` in 1: read strobe, qualified by chipselect.
- `avs_write` in 1: write strobe, qualified by chipselect.
- `avs_byteenable` in 4: write byte lanes.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: registered read data; read latency 1.
- `aes_key` out 128: key; word 0 maps to [127:96].
- `aes_msg_en` out 128: encrypted message; word 4 maps to [127:96].
- `aes_start` out 1: run request to the core.
- `aes_done` in 1: core completion, level.
- `aes_msg_de` in 128: decrypted message, valid while `aes_done`=1.
- `irq` out 1: level interrupt.
- `export_data` out 32: {`aes_key`[127:112], `aes_key`[15:0]}.

## Operation
- **Register map (word address):**
  - 0–3 KEY: RW, byte-enabled.
  - 4–7 MSG_EN: RW, byte-enabled.
  - 8–11 MSG_DE: RO, captured result.
  - 12 CTRL: bit0 START (write 1 launches; reads as BUSY), bit1 IRQ_EN (RW).
  - 13 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear), bit2 TIMEOUT (sticky, W1C).
  - 14 CYCLES: RO [15:0] latency of the last operation.
  - 15: reads 0, writes ignored.
  - Unused bits read 0.
- **FSM states:** IDLE, RUN, FIN.
  - IDLE→RUN on a CTRL write with byteenable[0]=1 and data bit0=1. The same edge clears the counter and clears DONE/TIMEOUT.
  - RUN: `aes_start`=1; counter increments every edge.
  - RUN→FIN on an edge with `aes_done`=1. The same edge captures `aes_msg_de` into MSG_DE, sets DONE, and sets CYCLES = counter+1.
  - RUN→FIN on an edge with `aes_done`=0 and counter+1 == `TIMEOUT`. The same edge sets TIMEOUT and CYCLES = `TIMEOUT`; MSG_DE is unchanged.
  - FIN: `aes_start`=0; FIN→IDLE on the first edge with `aes_done`=0.
- **BUSY** = state ≠ IDLE.
- **Writes while BUSY:** writes to KEY, MSG_EN and START are ignored. IRQ_EN and W1C writes are still accepted.
- **Interrupt:** `irq` = IRQ_EN & (DONE | TIMEOUT), combinational from registers.
- **Simultaneous events:** W1C in the same cycle as a hardware set — set wins. START write in the same cycle as a STATUS W1C write is not possible (single port).
- **Reset values:** all registers 0, state IDLE, `aes_start`=0, `irq`=0, `avs_readdata`=0, `export_data`=0.
- **Reset mid-operation:** `aes_start` drops asynchronously; MSG_DE is lost.

## Timing
- **Write:** takes effect at the edge where chipselect & write is sampled; zero wait states.
- **Read:** `avs_readdata` is valid the cycle after chipselect & read; it holds its value when no read is active.
- **Launch:** START written at edge N gives `aes_start`=1 from edge N and BUSY readable from N+1.
- **Minimum operation:** `aes_done` high at the first RUN edge gives CYCLES=1 and DONE set at edge N+1. `aes_start` is low after N+1, and the state is IDLE at N+2 if `aes_done` has fallen.
- **Timeout:** `aes_start` is high for exactly `TIMEOUT` cycles.
- **Counter:** 16-bit; cannot wrap because `TIMEOUT` ≤ 65535.
- **IRQ:** asserts the cycle after DONE or TIMEOUT sets, and deasserts the cycle after the W1C write.

## Structure
- **Package `aes_ctrl_pkg`:**
  - register address constants (ADDR_KEY0..ADDR_CYCLES);
  - CTRL/STATUS bit positions;
  - FSM state enum {IDLE, RUN, FIN};
  - counter width constant (16).
- **Sub-module `aes_ctrl_seq`:**
  - FSM, counter, timeout compare;
  - outputs `aes_start`, capture strobe, timeout strobe, cycle count.
- **Top:** register file, read mux and read-data register.

## Test plan
- **Register access:** write KEY0=0x00010203..KEY3=0x0C0D0E0F with byteenable 0xF, then byteenable 0x1 writes 0xFF to KEY0 → KEY0 reads 0x000102FF, `export_data`=0x00010E0F.
- **Normal run:** START, with core model asserting `aes_done` 11 cycles after `aes_start` and `aes_msg_de`=0xDEADBEEF_... → MSG_DE matches, DONE=1, CYCLES=11. With IRQ_EN=1, `irq`=1; `aes_start` is low the edge after done.
- **Timeout:** `TIMEOUT`=8, core never completes → `aes_start` high exactly 8 cycles, TIMEOUT=1, DONE=0, CYCLES=8, MSG_DE unchanged.
- **Write lock while busy:** during RUN, write KEY0=0x11111111 and write START again → KEY0 keeps its old value, no second launch; after completion, START relaunches with CYCLES reset.
- **W1C collision:** write STATUS=0x2 in the same cycle `aes_done` arrives → DONE reads 1 afterwards; a later write of 0x2 clears it and drops `irq`.
- **Reset mid-operation:** assert `reset_n` low during RUN → `aes_start`=0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared constants and types for the AES control register block:
// register map, CTRL/STATUS bit positions, sequencer states and helpers.
package aes_ctrl_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] ADDR_KEY0    = 4'd0;
  localparam logic [3:0] ADDR_KEY3    = 4'd3;
  localparam logic [3:0] ADDR_MSG_EN0 = 4'd4;
  localparam logic [3:0] ADDR_MSG_EN3 = 4'd7;
  localparam logic [3:0] ADDR_MSG_DE0 = 4'd8;
  localparam logic [3:0] ADDR_MSG_DE3 = 4'd11;
  localparam logic [3:0] ADDR_CTRL    = 4'd12;
  localparam logic [3:0] ADDR_STATUS  = 4'd13;
  localparam logic [3:0] ADDR_CYCLES  = 4'd14;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  function automatic logic [31:0] apply_byteenable(input logic [31:0] cur,
                                                   input logic [31:0] data,
                                                   input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_ctrl_seq.sv
// Run sequencer: holds aes_start while the core works, counts cycles,
// and flags completion or timeout on the edge that ends the run.
module aes_ctrl_seq
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             launch,
  input  logic             aes_done,
  output logic             aes_start,
  output logic             busy,
  output logic             capture,
  output logic             timeout_hit,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seq_state_t       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  assign count_next  = count + CNT_ONE;
  assign busy        = (state != IDLE);
  // Both strobes fire on the edge that leaves RUN; done takes priority.
  assign capture     = (state == RUN) && aes_done;
  assign timeout_hit = (state == RUN) && !aes_done && (count_next == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      cycles    <= '0;
      aes_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= RUN;
            count     <= '0;
            aes_start <= 1'b1;
          end
        end
        RUN: begin
          if (capture) begin
            state     <= FIN;
            cycles    <= count_next;
            aes_start <= 1'b0;
          end else if (timeout_hit) begin
            state     <= FIN;
            cycles    <= TIMEOUT_CNT;
            aes_start <= 1'b0;
          end else begin
            count <= count_next;
          end
        end
        FIN: begin
          aes_start <= 1'b0;
          if (!aes_done) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          aes_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aes_ctrl_regs.sv
// Avalon-MM register front end for the AES decryption core: key/message
// registers, result capture, status flags, interrupt and hex display export.
module aes_ctrl_regs
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   avs_address,
  input  logic         avs_chipselect,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [3:0]   avs_byteenable,
  input  logic [31:0]  avs_writedata,
  output logic [31:0]  avs_readdata,
  output logic [127:0] aes_key,
  output logic [127:0] aes_msg_en,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_msg_de,
  output logic         irq,
  output logic [31:0]  export_data
);

  logic [31:0]      key_q    [4];
  logic [31:0]      msg_en_q [4];
  logic [31:0]      msg_de_q [4];
  logic             irq_en;
  logic             done_flag;
  logic             timeout_flag;
  logic             busy;
  logic             capture;
  logic             timeout_hit;
  logic [CNT_W-1:0] cycles;
  logic [31:0]      rd_mux;

  logic wr_en;
  logic rd_en;
  logic data_wr;
  logic ctrl_wr;
  logic status_wr;
  logic launch;

  assign wr_en     = avs_chipselect && avs_write;
  assign rd_en     = avs_chipselect && avs_read;
  assign data_wr   = wr_en && !busy;
  assign ctrl_wr   = wr_en && (avs_address == ADDR_CTRL) && avs_byteenable[0];
  assign status_wr = wr_en && (avs_address == ADDR_STATUS) && avs_byteenable[0];
  assign launch    = ctrl_wr && avs_writedata[CTRL_START_BIT] && !busy;

  aes_ctrl_seq #(
    .TIMEOUT(TIMEOUT)
  ) u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .launch     (launch),
    .aes_done   (aes_done),
    .aes_start  (aes_start),
    .busy       (busy),
    .capture    (capture),
    .timeout_hit(timeout_hit),
    .cycles     (cycles)
  );

  // Hardware set of DONE/TIMEOUT wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i]    <= '0;
        msg_en_q[i] <= '0;
        msg_de_q[i] <= '0;
      end
      irq_en       <= 1'b0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (data_wr && (avs_address[3:2] == ADDR_KEY0[3:2])) begin
        key_q[avs_address[1:0]] <= apply_byteenable(key_q[avs_address[1:0]],
                                                    avs_writedata, avs_byteenable);
      end
      if (data_wr && (avs_address[3:2] == ADDR_MSG_EN0[3:2])) begin
        msg_en_q[avs_address[1:0]] <= apply_byteenable(msg_en_q[avs_address[1:0]],
                                                       avs_writedata, avs_byteenable);
      end
      if (capture) begin
        msg_de_q[0] <= aes_msg_de[127:96];
        msg_de_q[1] <= aes_msg_de[95:64];
        msg_de_q[2] <= aes_msg_de[63:32];
        msg_de_q[3] <= aes_msg_de[31:0];
      end
      if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];

      if (capture) begin
        done_flag <= 1'b1;
      end else if (launch || (status_wr && avs_writedata[STAT_DONE_BIT])) begin
        done_flag <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end else if (launch || (status_wr && avs_writedata[STAT_TIMEOUT_BIT])) begin
        timeout_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address[3:2])
      ADDR_KEY0[3:2]:    rd_mux = key_q[avs_address[1:0]];
      ADDR_MSG_EN0[3:2]: rd_mux = msg_en_q[avs_address[1:0]];
      ADDR_MSG_DE0[3:2]: rd_mux = msg_de_q[avs_address[1:0]];
      default: begin
        case (avs_address)
          ADDR_CTRL: begin
            rd_mux[CTRL_START_BIT]  = busy;
            rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
          end
          ADDR_STATUS: begin
            rd_mux[STAT_BUSY_BIT]    = busy;
            rd_mux[STAT_DONE_BIT]    = done_flag;
            rd_mux[STAT_TIMEOUT_BIT] = timeout_flag;
          end
          ADDR_CYCLES: rd_mux = {{(32-CNT_W){1'b0}}, cycles};
          default:     rd_mux = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (rd_en) begin
      avs_readdata <= rd_mux;
    end
  end

  assign aes_key     = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_msg_en  = {msg_en_q[0], msg_en_q[1], msg_en_q[2], msg_en_q[3]};
  assign irq         = irq_en && (done_flag || timeout_flag);
  assign export_data = {key_q[0][31:16], key_q[3][15:0]};

endmodule

// File: tb/tb_aes_ctrl_regs.sv
// Self-checking bench for aes_ctrl_regs: a register-level reference model of
// the main instance, plus a short-timeout instance for the expiry path.
module tb_aes_ctrl_regs;

  localparam int MAIN_TIMEOUT  = 4095;
  localparam int SHORT_TIMEOUT = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_FIN  = 2;

  localparam logic [3:0] A_KEY0   = 4'd0;
  localparam logic [3:0] A_MSGDE0 = 4'd8;
  localparam logic [3:0] A_CTRL   = 4'd12;
  localparam logic [3:0] A_STATUS = 4'd13;
  localparam logic [3:0] A_CYCLES = 4'd14;

  logic         clk            = 1'b0;
  logic         reset_n        = 1'b1;
  logic         cs_main        = 1'b0;
  logic         cs_to          = 1'b0;
  logic         avs_read       = 1'b0;
  logic         avs_write      = 1'b0;
  logic [3:0]   avs_address    = '0;
  logic [3:0]   avs_byteenable = '0;
  logic [31:0]  avs_writedata  = '0;
  logic         done_main      = 1'b0;
  logic         done_to        = 1'b0;
  logic [127:0] msg_de         = '0;

  logic [31:0]  rd_main, rd_to, exp_main, exp_to;
  logic [127:0] key_main, key_to, men_main, men_to;
  logic         start_main, start_to, irq_main, irq_to;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_ctrl_regs #(.TIMEOUT(MAIN_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_chipselect(cs_main), .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_readdata(rd_main), .aes_key(key_main), .aes_msg_en(men_main),
    .aes_start(start_main), .aes_done(done_main), .aes_msg_de(msg_de),
    .irq(irq_main), .export_data(exp_main)
  );

  aes_ctrl_regs #(.TIMEOUT(SHORT_TIMEOUT)) dut_to (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_chipselect(cs_to), .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_readdata(rd_to), .aes_key(key_to), .aes_msg_en(men_to),
    .aes_start(start_to), .aes_done(done_to), .aes_msg_de(msg_de),
    .irq(irq_to), .export_data(exp_to)
  );

  typedef struct packed {
    logic [0:3][31:0] key;
    logic [0:3][31:0] msg_en;
    logic [0:3][31:0] msg_de;
    logic             irq_en;
    logic             done;
    logic             timeout;
    int               phase;
    int               count;
    int               cycles;
    logic [31:0]      rdata;
  } model_t;

  model_t m;

  function automatic logic [31:0] model_read(input model_t s, input logic [3:0] a);
    logic [31:0] v;
    logic        run;
    v   = '0;
    run = (s.phase != PH_IDLE);
    if (a < 4'd4)       v = s.key[a[1:0]];
    else if (a < 4'd8)  v = s.msg_en[a[1:0]];
    else if (a < 4'd12) v = s.msg_de[a[1:0]];
    else if (a == 4'd12) v = {30'd0, s.irq_en, run};
    else if (a == 4'd13) v = {29'd0, s.timeout, s.done, run};
    else if (a == 4'd14) v = 32'(s.cycles);
    return v;
  endfunction

  function automatic model_t model_step(input model_t s, input logic cs, input logic rd,
                                        input logic wr, input logic [3:0] a,
                                        input logic [3:0] be, input logic [31:0] wd,
                                        input logic done, input logic [127:0] de);
    model_t n;
    logic   was_busy;
    logic   hw_done;
    logic   hw_timeout;
    n          = s;
    was_busy   = (s.phase != PH_IDLE);
    hw_done    = 1'b0;
    hw_timeout = 1'b0;
    if (cs && rd) n.rdata = model_read(s, a);
    if (s.phase == PH_RUN) begin
      if (done) begin
        hw_done  = 1'b1;
        n.msg_de = de;
        n.cycles = s.count + 1;
        n.phase  = PH_FIN;
      end else if (s.count + 1 == MAIN_TIMEOUT) begin
        hw_timeout = 1'b1;
        n.cycles   = MAIN_TIMEOUT;
        n.phase    = PH_FIN;
      end else begin
        n.count = s.count + 1;
      end
    end else if (s.phase == PH_FIN && !done) begin
      n.phase = PH_IDLE;
    end
    if (cs && wr) begin
      if (a < 4'd8 && !was_busy) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            if (a < 4'd4) n.key[a[1:0]][8*b +: 8] = wd[8*b +: 8];
            else          n.msg_en[a[1:0]][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
      if (a == 4'd12 && be[0]) begin
        n.irq_en = wd[1];
        if (wd[0] && !was_busy) begin
          n.phase   = PH_RUN;
          n.count   = 0;
          n.done    = 1'b0;
          n.timeout = 1'b0;
        end
      end
      if (a == 4'd13 && be[0]) begin
        if (wd[1]) n.done = 1'b0;
        if (wd[2]) n.timeout = 1'b0;
      end
    end
    if (hw_done) n.done = 1'b1;
    if (hw_timeout) n.timeout = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else m <= model_step(m, cs_main, avs_read, avs_write, avs_address, avs_byteenable,
                         avs_writedata, done_main, msg_de);
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Main instance against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("aes_start", 128'(start_main), 128'(m.phase == PH_RUN));
    checkOutput("irq", 128'(irq_main), 128'(m.irq_en & (m.done | m.timeout)));
    checkOutput("export_data", 128'(exp_main), 128'({m.key[0][31:16], m.key[3][15:0]}));
    checkOutput("aes_key", key_main, m.key);
    checkOutput("aes_msg_en", men_main, m.msg_en);
    checkOutput("avs_readdata", 128'(rd_main), 128'(m.rdata));
  end

  task automatic bus_write(input bit to_inst, input logic [3:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    cs_main        = !to_inst;
    cs_to          = to_inst;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_byteenable = be;
    avs_writedata  = d;
    @(negedge clk);
    cs_main   = 1'b0;
    cs_to     = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input bit to_inst, input logic [3:0] a, output logic [31:0] d);
    cs_main     = !to_inst;
    cs_to       = to_inst;
    avs_read    = 1'b1;
    avs_address = a;
    @(negedge clk);
    cs_main  = 1'b0;
    cs_to    = 1'b0;
    avs_read = 1'b0;
    d = to_inst ? rd_to : rd_main;
  endtask

  task automatic applyStimulus();
    logic [31:0] rd;
    logic [31:0] de_words [4];
    int          high_cycles;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(0, A_STATUS, rd);
    checkOutput("reset_status", 128'(rd), 128'h0);
    checkOutput("reset_export", 128'(exp_main), 128'h0);

    bus_write(0, 4'd0, 4'hF, 32'h00010203);
    bus_write(0, 4'd1, 4'hF, 32'h04050607);
    bus_write(0, 4'd2, 4'hF, 32'h08090A0B);
    bus_write(0, 4'd3, 4'hF, 32'h0C0D0E0F);
    bus_write(0, A_KEY0, 4'h1, 32'h000000FF);
    bus_read(0, A_KEY0, rd);
    checkOutput("key0_byte_lane", 128'(rd), 128'h000102FF);
    checkOutput("export_value", 128'(exp_main), 128'h00010E0F);
    bus_write(0, 4'd4, 4'hF, 32'h10111213);
    bus_write(0, 4'd5, 4'hF, 32'h14151617);
    bus_write(0, 4'd6, 4'hF, 32'h18191A1B);
    bus_write(0, 4'd7, 4'hF, 32'h1C1D1E1F);
    bus_write(0, 4'd15, 4'hF, 32'hFFFFFFFF);
    bus_read(0, 4'd15, rd);
    checkOutput("addr15_zero", 128'(rd), 128'h0);
    bus_write(0, A_CTRL, 4'hE, 32'h00000003);
    checkOutput("start_needs_lane0", 128'(start_main), 128'h0);

    // Normal run: done arrives 11 cycles after aes_start rises.
    msg_de = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
    bus_write(0, A_CTRL, 4'h1, 32'h00000003);
    checkOutput("start_launch", 128'(start_main), 128'h1);
    repeat (10) @(negedge clk);
    done_main = 1'b1;
    @(negedge clk);
    checkOutput("start_low_after_done", 128'(start_main), 128'h0);
    done_main = 1'b0;
    @(negedge clk);
    de_words = '{32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678};
    for (int i = 0; i < 4; i++) begin
      bus_read(0, A_MSGDE0 + 4'(i), rd);
      checkOutput("msg_de_word", 128'(rd), 128'(de_words[i]));
    end
    bus_read(0, A_STATUS, rd);
    checkOutput("status_done", 128'(rd), 128'h2);
    bus_read(0, A_CYCLES, rd);
    checkOutput("cycles_normal", 128'(rd), 128'd11);
    checkOutput("irq_on_done", 128'(irq_main), 128'h1);
    bus_write(0, A_STATUS, 4'h1, 32'h00000002);
    checkOutput("irq_after_w1c", 128'(irq_main), 128'h0);

    // Writes to KEY and START are locked out while busy.
    bus_write(0, A_CTRL, 4'h1, 32'h00000003);
    bus_write(0, A_KEY0, 4'hF, 32'h11111111);
    bus_write(0, A_CTRL, 4'h1, 32'h00000003);
    bus_read(0, A_CTRL, rd);
    checkOutput("ctrl_busy", 128'(rd), 128'h3);
    repeat (2) @(negedge clk);
    done_main = 1'b1;
    @(negedge clk);
    done_main = 1'b0;
    @(negedge clk);
    bus_read(0, A_KEY0, rd);
    checkOutput("key0_locked", 128'(rd), 128'h000102FF);
    bus_read(0, A_CYCLES, rd);
    checkOutput("cycles_locked_run", 128'(rd), 128'd6);
    checkOutput("no_second_launch", 128'(start_main), 128'h0);

    // Relaunch with a W1C of DONE landing on the completion edge.
    msg_de = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    bus_write(0, A_CTRL, 4'h1, 32'h00000003);
    @(negedge clk);
    done_main = 1'b1;
    bus_write(0, A_STATUS, 4'h1, 32'h00000002);
    done_main = 1'b0;
    @(negedge clk);
    bus_read(0, A_STATUS, rd);
    checkOutput("w1c_set_wins", 128'(rd), 128'h2);
    bus_read(0, A_CYCLES, rd);
    checkOutput("cycles_restart", 128'(rd), 128'd2);
    checkOutput("irq_collision", 128'(irq_main), 128'h1);
    bus_write(0, A_STATUS, 4'h1, 32'h00000002);
    checkOutput("irq_cleared", 128'(irq_main), 128'h0);
    bus_read(0, A_STATUS, rd);
    checkOutput("status_cleared", 128'(rd), 128'h0);

    // Short-timeout instance: a completed run, then an expiring one.
    msg_de = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    bus_write(1, A_CTRL, 4'h1, 32'h00000003);
    repeat (2) @(negedge clk);
    done_to = 1'b1;
    @(negedge clk);
    done_to = 1'b0;
    @(negedge clk);
    bus_read(1, A_CYCLES, rd);
    checkOutput("to_prerun_cycles", 128'(rd), 128'd3);
    msg_de = '1;
    bus_write(1, A_CTRL, 4'h1, 32'h00000003);
    high_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (start_to) high_cycles++;
      else break;
      @(negedge clk);
    end
    checkOutput("timeout_start_cycles", 128'(high_cycles), 128'd8);
    @(negedge clk);
    bus_read(1, A_STATUS, rd);
    checkOutput("timeout_status", 128'(rd), 128'h4);
    bus_read(1, A_CYCLES, rd);
    checkOutput("timeout_cycles", 128'(rd), 128'd8);
    bus_read(1, A_MSGDE0, rd);
    checkOutput("timeout_msg_de_kept", 128'(rd), 128'hA5A5A5A5);
    checkOutput("timeout_irq", 128'(irq_to), 128'h1);

    // Reset in the middle of a run.
    bus_write(0, A_CTRL, 4'h1, 32'h00000001);
    @(negedge clk);
    checkOutput("start_before_reset", 128'(start_main), 128'h1);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_async_start", 128'(start_main), 128'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus_read(0, 4'(a), rd);
      checkOutput("post_reset_reg", 128'(rd), 128'h0);
    end
    checkOutput("post_reset_export", 128'(exp_main), 128'h0);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
